// File: rtl/any1_fu_result_arb_pkg.sv
// Shared types for the ANY-1 result-bus arbiter: unit codes, index type and
// the functional-unit result record handed to the reorder buffer.
package any1_fu_result_arb_pkg;

  localparam int NFU = 5;
  localparam int FUW = 3;

  typedef logic [2:0] FuIndex;

  localparam FuIndex FU_EXEC = 3'd0;
  localparam FuIndex FU_MUL  = 3'd1;
  localparam FuIndex FU_DIV  = 3'd2;
  localparam FuIndex FU_MEM  = 3'd3;
  localparam FuIndex FU_FP   = 3'd4;

  localparam logic [7:0] FLT_NONE = 8'h00;

  typedef struct packed {
    logic        cmt;
    logic [5:0]  rid;
    logic [1:0]  ele;
    logic [7:0]  cause;
    logic [63:0] badAddr;
    logic [63:0] res;
  } sFuncUnit;

endpackage

// File: rtl/any1_rr_picker.sv
// Rotating-priority first-one finder: scans req_i from start_i upward,
// wrapping at NFU, and returns the first set request one-hot and encoded.
module any1_rr_picker
  import any1_fu_result_arb_pkg::*;
(
  input  logic [NFU-1:0] req_i,
  input  FuIndex         start_i,
  output logic [NFU-1:0] grant_o,
  output FuIndex         idx_o,
  output logic           any_o
);

  always_comb begin
    int u;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    u       = 0;
    for (int k = 0; k < NFU; k++) begin
      u = (int'(start_i) + k) % NFU;
      if (!any_o && req_i[u]) begin
        any_o      = 1'b1;
        grant_o[u] = 1'b1;
        idx_o      = FuIndex'(u);
      end
    end
  end

endmodule

// File: rtl/any1_fu_result_arb.sv
// Result-bus arbiter: one holding register per functional unit, round-robin
// grant of one held record per cycle onto the registered ROB write port.
module any1_fu_result_arb
  import any1_fu_result_arb_pkg::sFuncUnit;
  import any1_fu_result_arb_pkg::FuIndex;
#(
  parameter int NFU = 5,
  parameter int FUW = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  input  logic           rob_stall_i,
  input  logic [NFU-1:0] fu_v_i,
  input  sFuncUnit       fu_i [NFU],
  output logic [NFU-1:0] fu_rdy_o,
  output logic           rob_wr_o,
  output sFuncUnit       rob_fu_o,
  output logic [FUW-1:0] rob_unit_o
);

  logic [NFU-1:0] hold_v_q, hold_v_d;
  sFuncUnit       hold_q [NFU];
  FuIndex         rr_ptr_q;

  logic [NFU-1:0] pick_grant, grant_eff, accept;
  FuIndex         pick_idx;
  logic           pick_any, do_grant;

  logic           rob_wr_q;
  sFuncUnit       rob_fu_q;
  logic [FUW-1:0] rob_unit_q;

  any1_rr_picker u_picker (
    .req_i   (hold_v_q),
    .start_i (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Handshake: a record moves when fu_v_i & fu_rdy_o at a rising edge. Ready
  // depends only on state, flush and the grant, never on fu_v_i, so a unit
  // that keeps winning can refill its slot every cycle.
  always_comb begin
    do_grant  = pick_any & ~flush_i & ~rob_stall_i;
    grant_eff = do_grant ? pick_grant : '0;
    fu_rdy_o  = flush_i ? '0 : (~hold_v_q | grant_eff);
    accept    = fu_v_i & fu_rdy_o;
    hold_v_d  = flush_i ? '0 : ((hold_v_q & ~grant_eff) | accept);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_v_q   <= '0;
      rr_ptr_q   <= '0;
      rob_wr_q   <= 1'b0;
      rob_fu_q   <= '0;
      rob_unit_q <= '0;
      for (int i = 0; i < NFU; i++) hold_q[i] <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      rob_wr_q <= do_grant;
      for (int i = 0; i < NFU; i++) begin
        if (accept[i]) hold_q[i] <= fu_i[i];
      end
      // Without a grant the last record and unit stay on the port.
      if (do_grant) begin
        rob_fu_q   <= hold_q[pick_idx];
        rob_unit_q <= FUW'(pick_idx);
        rr_ptr_q   <= (pick_idx == FuIndex'(NFU - 1)) ? '0 : pick_idx + FuIndex'(1);
      end
    end
  end

  assign rob_wr_o   = rob_wr_q;
  assign rob_fu_o   = rob_fu_q;
  assign rob_unit_o = rob_unit_q;

endmodule

// File: tb/tb_any1_fu_result_arb.sv
// Directed bench for the result-bus arbiter with an expected-write queue
// drained by an independent ROB-port monitor.
module tb_any1_fu_result_arb;
  import any1_fu_result_arb_pkg::*;

  localparam int W = FUW + $bits(sFuncUnit);

  logic           clk;
  logic           rst_i;
  logic           flush_i;
  logic           rob_stall_i;
  logic [NFU-1:0] fu_v_i;
  sFuncUnit       fu_i [NFU];
  logic [NFU-1:0] fu_rdy_o;
  logic           rob_wr_o;
  sFuncUnit       rob_fu_o;
  logic [FUW-1:0] rob_unit_o;

  int             n_cmp;
  int             n_err;
  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   mon_e;

  any1_fu_result_arb dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .rob_stall_i (rob_stall_i),
    .fu_v_i      (fu_v_i),
    .fu_i        (fu_i),
    .fu_rdy_o    (fu_rdy_o),
    .rob_wr_o    (rob_wr_o),
    .rob_fu_o    (rob_fu_o),
    .rob_unit_o  (rob_unit_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic sFuncUnit mk(input logic [5:0] rid, input logic [63:0] res,
                                  input logic [7:0] cause);
    sFuncUnit r;
    r         = '0;
    r.cmt     = 1'b1;
    r.rid     = rid;
    r.ele     = rid[1:0];
    r.cause   = cause;
    r.badAddr = {56'h0, cause} ^ 64'hA5A5_0000_0000_00A5;
    r.res     = res;
    return r;
  endfunction

  // driver tasks
  task automatic expect_w(input FuIndex u, input sFuncUnit r);
    exp_q.push_back({u, r});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    flush_i     = 1'b0;
    rob_stall_i = 1'b0;
    fu_v_i      = '0;
    tick(2);
    rst_i = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    tick(1);
    chk(nm, W'(exp_q.size()), '0);
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_i && rob_wr_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got unit %0d rid %0d expected no write",
                   rob_unit_o, rob_fu_o.rid);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rob_write", {rob_unit_o, rob_fu_o}, mon_e);
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < NFU; i++) fu_i[i] = '0;
    do_reset();

    // reset state
    chk("reset_rob_wr", W'(rob_wr_o), '0);
    chk("reset_rob_unit", W'(rob_unit_o), '0);
    chk("reset_rob_fu", W'(rob_fu_o), '0);
    chk("reset_rdy", W'(fu_rdy_o), W'(5'b11111));
    chk("reset_rr_ptr", W'(dut.rr_ptr_q), '0);

    // single record from FU_MUL
    fu_i[FU_MUL] = mk(6'd5, 64'h1234, FLT_NONE);
    fu_v_i       = 5'b00010;
    expect_w(FU_MUL, fu_i[FU_MUL]);
    tick(1);
    fu_v_i = '0;
    tick(1);
    chk("single_wr", W'(rob_wr_o), W'(1'b1));
    chk("single_unit", W'(rob_unit_o), W'(FU_MUL));
    chk("single_rid", W'(rob_fu_o.rid), W'(6'd5));
    chk("single_rr_ptr", W'(dut.rr_ptr_q), W'(3'd2));
    drain("single_drain");

    // all five units at once from rr_ptr=0
    do_reset();
    for (int u = 0; u < NFU; u++) begin
      fu_i[u] = mk(6'(10 + u), 64'h1000 + 64'(u), (u == 3) ? 8'h27 : FLT_NONE);
      expect_w(FuIndex'(u), fu_i[u]);
    end
    fu_v_i = 5'b11111;
    tick(1);
    fu_v_i = '0;
    tick(5);
    chk("all5_last_unit", W'(rob_unit_o), W'(FU_FP));
    tick(1);
    chk("all5_idle_after", W'(rob_wr_o), '0);
    chk("all5_rr_ptr", W'(dut.rr_ptr_q), '0);
    drain("all5_drain");

    // wrap-around: move rr_ptr to 4, then hold units 4 and 0 together
    fu_i[FU_MEM] = mk(6'd20, 64'hBEEF, FLT_NONE);
    fu_v_i       = 5'b01000;
    expect_w(FU_MEM, fu_i[FU_MEM]);
    tick(1);
    fu_v_i = '0;
    tick(3);
    chk("wrap_rr_at4", W'(dut.rr_ptr_q), W'(3'd4));
    fu_i[FU_FP]   = mk(6'd21, 64'hF0F0, FLT_NONE);
    fu_i[FU_EXEC] = mk(6'd22, 64'h0E0E, 8'h11);
    fu_v_i        = 5'b10001;
    expect_w(FU_FP, fu_i[FU_FP]);
    expect_w(FU_EXEC, fu_i[FU_EXEC]);
    tick(1);
    fu_v_i = '0;
    tick(4);
    chk("wrap_rr_end", W'(dut.rr_ptr_q), W'(3'd1));
    drain("wrap_drain");

    // stall with units 0, 2, 3 held; rr_ptr=1 so release order is 2, 3, 0
    rob_stall_i   = 1'b1;
    fu_i[FU_EXEC] = mk(6'd30, 64'h3000, FLT_NONE);
    fu_i[FU_DIV]  = mk(6'd32, 64'h3002, 8'h05);
    fu_i[FU_MEM]  = mk(6'd33, 64'h3003, FLT_NONE);
    fu_v_i        = 5'b01101;
    expect_w(FU_DIV, fu_i[FU_DIV]);
    expect_w(FU_MEM, fu_i[FU_MEM]);
    expect_w(FU_EXEC, fu_i[FU_EXEC]);
    tick(1);
    fu_v_i = '0;
    for (int c = 0; c < 4; c++) begin
      chk("stall_rdy", W'(fu_rdy_o), W'(5'b10010));
      chk("stall_no_wr", W'(rob_wr_o), '0);
      tick(1);
    end
    rob_stall_i = 1'b0;
    tick(5);
    chk("stall_rr_end", W'(dut.rr_ptr_q), W'(3'd1));
    drain("stall_drain");

    // flush while FU_EXEC is held and FU_DIV presents a record
    rob_stall_i   = 1'b1;
    fu_i[FU_EXEC] = mk(6'd40, 64'h4000, FLT_NONE);
    fu_v_i        = 5'b00001;
    tick(1);
    rob_stall_i  = 1'b0;
    flush_i      = 1'b1;
    fu_i[FU_DIV] = mk(6'd42, 64'h4002, 8'h27);
    fu_v_i       = 5'b00100;
    #1;
    chk("flush_rdy", W'(fu_rdy_o), '0);
    tick(1);
    flush_i = 1'b0;
    fu_v_i  = '0;
    chk("flush_no_wr", W'(rob_wr_o), '0);
    chk("flush_hold_v", W'(dut.hold_v_q), '0);
    chk("flush_rr_kept", W'(dut.rr_ptr_q), W'(3'd1));
    tick(3);

    // streaming from FU_EXEC alone for 10 cycles
    for (int i = 0; i < 10; i++) begin
      fu_i[FU_EXEC] = mk(6'(50 + i), 64'h5000 + 64'(i), FLT_NONE);
      fu_v_i        = 5'b00001;
      expect_w(FU_EXEC, fu_i[FU_EXEC]);
      #1;
      chk("stream_rdy0", W'(fu_rdy_o[0]), W'(1'b1));
      tick(1);
      if (i >= 1) begin
        chk("stream_wr", W'(rob_wr_o), W'(1'b1));
        chk("stream_unit", W'(rob_unit_o), W'(FU_EXEC));
      end
    end
    fu_v_i = '0;
    tick(1);
    chk("stream_last_wr", W'(rob_wr_o), W'(1'b1));
    tick(1);
    chk("stream_end_idle", W'(rob_wr_o), '0);
    drain("stream_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
